nibble_mult_seq: RTL and testbench

- Sequencer and accumulator wrapped around the 4x4 registered nibble multiplier.
- Accepts two WIDTH-bit operands over a valid/ready handshake.
- Issues every nibble pair to the multiplier, one per cycle, and consumes each 8-bit product one cycle later.
- Shift-accumulates the products into a 2*WIDTH result, which it returns over a valid/ready handshake.
- Sits between the operand input pins and the output pins; the multiplier is its only datapath neighbour.

---
 rtl/nibble_mult_pkg.sv | 26 ++
 rtl/nibble_mult_seq_if.sv | 22 ++
 rtl/nibble_mult_seq_pp_shift_acc.sv | 42 ++++
 rtl/nibble_mult_seq.sv | 132 +++++++++++++
 tb/tb_nibble_mult_seq.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_mult_pkg.sv
// Shared types and sizing helpers for the nibble-serial multiplier sequencer.
package nibble_mult_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned DefaultWidth = 16;

    function automatic int unsigned nib_of(input int unsigned width);
        return width / 4;
    endfunction

    function automatic int unsigned acc_w_of(input int unsigned width);
        return 2 * width;
    endfunction

    // Pair counters index 0..NIB-1; never narrower than one bit.
    function automatic int unsigned cnt_w_of(input int unsigned width);
        return (width / 4 > 1) ? $clog2(width / 4) : 1;
    endfunction

endpackage

// File: rtl/nibble_mult_seq_if.sv
// Operand and result handshakes of the nibble multiplier sequencer.
interface nibble_mult_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/nibble_mult_seq_pp_shift_acc.sv
// Partial-product tag pipeline and shift-accumulator; consumes each product one edge after issue.
module pp_shift_acc #(
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned SHIFT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               ena_i,
    input  logic               clear_i,
    input  logic               issue_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic [7:0]         mul_p_i,
    output logic [ACC_W-1:0]   acc_o
);
    logic               tag_valid_q;
    logic [SHIFT_W-1:0] tag_shift_q;
    logic [ACC_W-1:0]   acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (tag_valid_q) begin
            acc_d = acc_q + (ACC_W'(mul_p_i) << tag_shift_q);
        end
    end

    // The tag tracks the product currently sitting in the multiplier register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_valid_q <= 1'b0;
            tag_shift_q <= '0;
            acc_q       <= '0;
        end else if (ena_i) begin
            tag_valid_q <= issue_i;
            tag_shift_q <= shift_i;
            acc_q       <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/nibble_mult_seq.sv
// Sequencer around a registered 4x4 multiplier: issues all nibble pairs and accumulates a full product.
module nibble_mult_seq
    import nibble_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ena_i,
    nibble_mult_seq_if.slave bus,
    output logic [3:0]       mul_a_o,
    output logic [3:0]       mul_b_o,
    input  logic [7:0]       mul_p_i
);
    localparam int unsigned NIB     = nib_of(WIDTH);
    localparam int unsigned ACC_W   = acc_w_of(WIDTH);
    localparam int unsigned CNT_W   = cnt_w_of(WIDTH);
    localparam int unsigned SHIFT_W = $clog2(ACC_W);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t Last = cnt_t'(NIB - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    cnt_t             i_q, i_d, j_q, j_d, pi_q, pi_d, pj_q, pj_d;
    logic             accept, issue;
    logic [SHIFT_W-1:0] issue_shift;
    logic [ACC_W-1:0]   acc;

    function automatic logic [3:0] nibble(input logic [WIDTH-1:0] v, input cnt_t idx);
        return v[{idx, 2'b00} +: 4];
    endfunction

    assign issue_shift = SHIFT_W'({i_q, 2'b00}) + SHIFT_W'({j_q, 2'b00});

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        i_d     = i_q;
        j_d     = j_q;
        pi_d    = pi_q;
        pj_d    = pj_q;
        accept  = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    op_a_d  = bus.op_a;
                    op_b_d  = bus.op_b;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                issue = 1'b1;
                pi_d  = i_q;
                pj_d  = j_q;
                if (i_q == Last) begin
                    i_d = '0;
                    if (j_q == Last) begin
                        state_d = StDrain;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            StDrain: state_d = StDone;
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            pi_q    <= '0;
            pj_q    <= '0;
        end else if (ena_i) begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            i_q     <= i_d;
            j_q     <= j_d;
            pi_q    <= pi_d;
            pj_q    <= pj_d;
        end
    end

    // While paused or draining, replay the pending pair so the ungated multiplier keeps its product.
    always_comb begin
        mul_a_o = '0;
        mul_b_o = '0;
        if (state_q == StIssue && ena_i) begin
            mul_a_o = nibble(op_a_q, i_q);
            mul_b_o = nibble(op_b_q, j_q);
        end else if (state_q == StIssue || state_q == StDrain) begin
            mul_a_o = nibble(op_a_q, pi_q);
            mul_b_o = nibble(op_b_q, pj_q);
        end
    end

    pp_shift_acc #(
        .ACC_W   (ACC_W),
        .SHIFT_W (SHIFT_W)
    ) u_acc (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .ena_i   (ena_i),
        .clear_i (accept),
        .issue_i (issue),
        .shift_i (issue_shift),
        .mul_p_i (mul_p_i),
        .acc_o   (acc)
    );

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = acc;
endmodule

// File: tb/tb_nibble_mult_seq.sv
// Bench for nibble_mult_seq: WIDTH=16 and WIDTH=8 instances against a transaction-level model.
module tb_nibble_mult_seq;
    logic clk;
    logic rst_n;
    logic ena;

    logic [1:0]       iv, ordy, ir, ov;
    logic [1:0][31:0] opa, opb;
    logic [1:0][63:0] res;

    logic [3:0] ma16, mb16, ma8, mb8;
    logic [7:0] p16, p8;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_hs = 0;

    // Model state per instance: busy, enabled edges since accept, expected product.
    bit        m_busy [2];
    int        m_cnt  [2];
    logic [63:0] m_exp [2];

    nibble_mult_seq_if #(.WIDTH(16)) bus16 ();
    nibble_mult_seq_if #(.WIDTH(8))  bus8 ();

    assign bus16.in_valid  = iv[0];
    assign bus16.op_a      = opa[0][15:0];
    assign bus16.op_b      = opb[0][15:0];
    assign bus16.out_ready = ordy[0];
    assign bus8.in_valid   = iv[1];
    assign bus8.op_a       = opa[1][7:0];
    assign bus8.op_b       = opb[1][7:0];
    assign bus8.out_ready  = ordy[1];
    assign ir  = {bus8.in_ready, bus16.in_ready};
    assign ov  = {bus8.out_valid, bus16.out_valid};
    assign res[0] = 64'(bus16.result);
    assign res[1] = 64'(bus8.result);

    nibble_mult_seq #(.WIDTH(16)) dut16 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .ena_i   (ena),
        .bus     (bus16),
        .mul_a_o (ma16),
        .mul_b_o (mb16),
        .mul_p_i (p16)
    );

    nibble_mult_seq #(.WIDTH(8)) dut8 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .ena_i   (ena),
        .bus     (bus8),
        .mul_a_o (ma8),
        .mul_b_o (mb8),
        .mul_p_i (p8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered 4x4 multipliers, not gated by ena.
    initial begin
        p16 = 8'h00;
        p8  = 8'h00;
    end
    always @(posedge clk) begin
        p16 <= 8'(ma16) * 8'(mb16);
        p8  <= 8'(ma8) * 8'(mb8);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] op_mask(input int k);
        return (k == 0) ? 64'hFFFF : 64'hFF;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 17 : 5;
    endfunction

    // Per-cycle compare against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_busy[k] = 1'b0;
                m_cnt[k]  = 0;
                chk("rst_in_ready", 64'(ir[k]), 64'd1);
                chk("rst_out_valid", 64'(ov[k]), 64'd0);
            end else begin
                chk("in_ready", 64'(ir[k]), 64'(!m_busy[k]));
                chk("out_valid", 64'(ov[k]), 64'(m_busy[k] && m_cnt[k] == lat_of(k)));
                if (m_busy[k] && m_cnt[k] == lat_of(k)) chk("result", res[k], m_exp[k]);
                if (ena) begin
                    if (!m_busy[k] && iv[k]) begin
                        m_busy[k] = 1'b1;
                        m_cnt[k]  = 0;
                        m_exp[k]  = (64'(opa[k]) & op_mask(k)) * (64'(opb[k]) & op_mask(k));
                    end else if (m_busy[k] && m_cnt[k] < lat_of(k)) begin
                        m_cnt[k]++;
                    end else if (m_busy[k] && ordy[k]) begin
                        m_busy[k] = 1'b0;
                    end
                end
            end
        end
    end

    // Called at posedge+1 with the target idle; returns at posedge+1 after the result handshake.
    // pmask bit e holds ena low for edge e+1 after accept; exp_lat < 0 skips the literal latency check.
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_lat, input logic [31:0] pmask,
                          input int stall, input bit poke, input bit b2b);
        int edges;
        bit got;
        opa[k]  = a;
        opb[k]  = b;
        iv[k]   = 1'b1;
        ordy[k] = (stall == 0);
        got = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            got = ir[k] && ena;
            @(posedge clk);
            #1;
            if (got) break;
        end
        iv[k] = 1'b0;
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
        if (b2b) chk("b2b_accept_cycle", 64'(cyc), 64'(last_hs + 1));
        edges = 0;
        ena   = !pmask[0];
        got   = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ov[k]) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            edges++;
            ena = (edges < 32) ? !pmask[edges] : 1'b1;
        end
        ena = 1'b1;
        if (!got) begin
            chk("out_valid_timeout", 64'd0, 64'd1);
        end else begin
            if (exp_lat >= 0) chk("latency", 64'(edges), 64'(exp_lat));
            chk("result_literal", res[k], exp);
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            iv[k] = poke;
            opb[k] = ~b;
            @(negedge clk);
            chk("stall_result_hold", res[k], exp);
            chk("stall_in_ready", 64'(ir[k]), 64'd0);
        end
        iv[k]   = 1'b0;
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        last_hs = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, pm;
        int k;
        rst_n = 1'b0;
        ena   = 1'b1;
        iv    = '0;
        ordy  = 2'b11;
        opa   = '0;
        opb   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result16", res[0], 64'd0);
        chk("rst_result8", res[1], 64'd0);
        chk("rst_mul_a", 64'(ma16), 64'd0);
        chk("rst_mul_b", 64'(mb16), 64'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(0, 32'hFFFF, 32'hFFFF, 64'hFFFE0001, 17, 32'd0, 0, 1'b0, 1'b0);
        run_op(0, 32'h1234, 32'h5678, 64'h06260060, 17, 32'd0, 0, 1'b0, 1'b0);
        run_op(0, 32'h0000, 32'hABCD, 64'h0, 17, 32'd0, 0, 1'b0, 1'b1);
        run_op(0, 32'h00FF, 32'h0101, 64'h0000FFFF, 17, 32'd0, 5, 1'b1, 1'b0);
        // Pause edges 8..10 after the 7th pair and one edge in DRAIN.
        run_op(0, 32'h1234, 32'h5678, 64'h06260060, 21, 32'h0008_0380, 0, 1'b0, 1'b0);

        // Abandon an operation with an asynchronous reset between edges.
        opa[0] = 32'h1234;
        opb[0] = 32'h5678;
        iv[0]  = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(ov[0]), 64'd0);
        chk("async_rst_in_ready", 64'(ir[0]), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(0, 32'h8000, 32'h0002, 64'h00010000, 17, 32'd0, 0, 1'b0, 1'b0);

        run_op(1, 32'hFF, 32'hFF, 64'hFE01, 5, 32'd0, 0, 1'b0, 1'b0);
        run_op(1, 32'h0F, 32'hF0, 64'h0E10, 5, 32'd0, 0, 1'b0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            k  = (r % 3 == 2) ? 1 : 0;
            a  = $urandom & 32'(op_mask(k));
            b  = $urandom & 32'(op_mask(k));
            pm = $urandom & $urandom & $urandom & ((k == 0) ? 32'h0000_FFFE : 32'h0000_0006);
            run_op(k, a, b, (64'(a) * 64'(b)), -1, pm, int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
